image_mem_responder: RTL and testbench

- Responder side of the image-memory interface driven by the downscaler control unit. That unit issues `mem_addr`/`mem_we`/`mem_data_out` and samples `mem_data_in` one clock after its address register updates.
- The block owns a single-port byte RAM holding the source image (0x0000..OUT_BASE-1) and the result image (OUT_BASE and up).
- It arbitrates that RAM between the core port and a host loader/readback port.
- It enforces region and range protection and keeps access statistics.

---
 rtl/image_mem_responder_if.sv | 36 +++
 rtl/image_mem_responder.sv | 163 ++++++++++++++++
 tb/tb_image_mem_responder.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/image_mem_responder_if.sv
// Bus bundle between the image-memory responder and its two clients:
// the downscaler core port, the host loader/readback port and the statistics outputs.
interface image_mem_responder_if;
    logic        core_busy;
    logic        core_ce;
    logic        core_we;
    logic [15:0] core_addr;
    logic [7:0]  core_wdata;
    logic [7:0]  core_rdata;
    logic        host_req;
    logic        host_we;
    logic [15:0] host_addr;
    logic [7:0]  host_wdata;
    logic        host_gnt;
    logic        host_rvalid;
    logic [7:0]  host_rdata;
    logic        clr_stats;
    logic [31:0] rd_count;
    logic [31:0] wr_count;
    logic        err_range;
    logic        err_wprot;

    modport master (
        output core_busy, core_ce, core_we, core_addr, core_wdata,
        output host_req, host_we, host_addr, host_wdata, clr_stats,
        input  core_rdata, host_gnt, host_rvalid, host_rdata,
        input  rd_count, wr_count, err_range, err_wprot
    );

    modport slave (
        input  core_busy, core_ce, core_we, core_addr, core_wdata,
        input  host_req, host_we, host_addr, host_wdata, clr_stats,
        output core_rdata, host_gnt, host_rvalid, host_rdata,
        output rd_count, wr_count, err_range, err_wprot
    );
endinterface

// File: rtl/image_mem_responder.sv
// Single-port byte RAM shared between the downscaler core and a host loader, with
// ownership hand-over FSM, write/range protection and access statistics.
module image_mem_responder #(
    parameter int          MEM_DEPTH = 32768,
    parameter logic [15:0] OUT_BASE  = 16'h4000,
    parameter int          RD_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  sclr,
    image_mem_responder_if.slave  bus
);

    localparam int          AW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);

    typedef enum logic [1:0] {
        HOST_OWN = 2'd0,
        DRAIN    = 2'd1,
        CORE_OWN = 2'd2
    } own_e;

    own_e        state_q, state_d;
    logic [7:0]  mem_q [MEM_DEPTH];

    logic [7:0]  core_s1_q, core_s1_d;
    logic [7:0]  core_rdata_q, core_rdata_d;
    logic        host_v1_q, host_v1_d;
    logic [7:0]  host_d1_q, host_d1_d;
    logic        host_rvalid_q, host_rvalid_d;
    logic [7:0]  host_rdata_q, host_rdata_d;
    logic [31:0] rd_count_q, rd_count_d;
    logic [31:0] wr_count_q, wr_count_d;
    logic        err_range_q, err_range_d;
    logic        err_wprot_q, err_wprot_d;

    logic          host_gnt_s, core_acc_s;
    logic          host_oor_s, core_oor_s, mem_oor_s;
    logic          core_wprot_s, core_wr_ok_s, core_rd_s;
    logic          host_wr_ok_s, host_rd_s, mem_we_s;
    logic [AW-1:0] mem_idx_s;
    logic [7:0]    mem_wdata_s, rd_byte_s;

    // Access decode: at most one port touches the RAM in any cycle, chosen by ownership.
    always_comb begin
        host_gnt_s   = bus.host_req & (state_q == HOST_OWN) & ~bus.core_busy;
        core_acc_s   = (state_q == CORE_OWN) & bus.core_ce;
        host_oor_s   = ({16'd0, bus.host_addr} >= DEPTH_W);
        core_oor_s   = ({16'd0, bus.core_addr} >= DEPTH_W);
        core_wprot_s = core_acc_s & bus.core_we & (bus.core_addr < OUT_BASE);
        core_wr_ok_s = core_acc_s & bus.core_we & ~core_oor_s & ~core_wprot_s;
        core_rd_s    = core_acc_s & ~bus.core_we;
        host_wr_ok_s = host_gnt_s & bus.host_we & ~host_oor_s;
        host_rd_s    = host_gnt_s & ~bus.host_we;
        mem_we_s     = ~sclr & (core_wr_ok_s | host_wr_ok_s);
        if (core_acc_s) begin
            mem_idx_s   = bus.core_addr[AW-1:0];
            mem_oor_s   = core_oor_s;
            mem_wdata_s = bus.core_wdata;
        end else begin
            mem_idx_s   = bus.host_addr[AW-1:0];
            mem_oor_s   = host_oor_s;
            mem_wdata_s = bus.host_wdata;
        end
        if (mem_oor_s) begin
            rd_byte_s = 8'h00;
        end else begin
            rd_byte_s = mem_q[mem_idx_s];
        end
    end

    // Next-state for ownership FSM, read pipelines, counters and sticky flags.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HOST_OWN: begin
                if (bus.core_busy) state_d = DRAIN;
                else               state_d = HOST_OWN;
            end
            DRAIN:    state_d = CORE_OWN;
            CORE_OWN: begin
                if (bus.core_busy) state_d = CORE_OWN;
                else               state_d = HOST_OWN;
            end
            default:  state_d = HOST_OWN;
        endcase

        core_s1_d = core_rd_s ? rd_byte_s : core_s1_q;
        if (RD_LAT == 2) begin
            core_rdata_d = core_acc_s ? core_s1_q : core_rdata_q;
        end else begin
            core_rdata_d = core_s1_d;
        end

        host_v1_d = host_rd_s;
        host_d1_d = host_rd_s ? rd_byte_s : host_d1_q;
        if (RD_LAT == 2) begin
            host_rvalid_d = host_v1_q;
            host_rdata_d  = host_v1_q ? host_d1_q : host_rdata_q;
        end else begin
            host_rvalid_d = host_rd_s;
            host_rdata_d  = host_d1_d;
        end

        // A clear in the same cycle as an event discards that event.
        if (bus.clr_stats) begin
            rd_count_d  = 32'd0;
            wr_count_d  = 32'd0;
            err_range_d = 1'b0;
            err_wprot_d = 1'b0;
        end else begin
            rd_count_d  = rd_count_q + 32'(core_rd_s);
            wr_count_d  = wr_count_q + 32'(core_wr_ok_s);
            err_range_d = err_range_q | (core_acc_s & core_oor_s) | (host_gnt_s & host_oor_s);
            err_wprot_d = err_wprot_q | core_wprot_s;
        end
    end

    // State and output registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q       <= HOST_OWN;
            core_s1_q     <= 8'h00;
            core_rdata_q  <= 8'h00;
            host_v1_q     <= 1'b0;
            host_d1_q     <= 8'h00;
            host_rvalid_q <= 1'b0;
            host_rdata_q  <= 8'h00;
            rd_count_q    <= 32'd0;
            wr_count_q    <= 32'd0;
            err_range_q   <= 1'b0;
            err_wprot_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            core_s1_q     <= core_s1_d;
            core_rdata_q  <= core_rdata_d;
            host_v1_q     <= host_v1_d;
            host_d1_q     <= host_d1_d;
            host_rvalid_q <= host_rvalid_d;
            host_rdata_q  <= host_rdata_d;
            rd_count_q    <= rd_count_d;
            wr_count_q    <= wr_count_d;
            err_range_q   <= err_range_d;
            err_wprot_q   <= err_wprot_d;
        end
    end

    // RAM write port; contents survive sclr.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_idx_s] <= mem_wdata_s;
        end
    end

    assign bus.core_rdata  = core_rdata_q;
    assign bus.host_gnt    = host_gnt_s;
    assign bus.host_rvalid = host_rvalid_q;
    assign bus.host_rdata  = host_rdata_q;
    assign bus.rd_count    = rd_count_q;
    assign bus.wr_count    = wr_count_q;
    assign bus.err_range   = err_range_q;
    assign bus.err_wprot   = err_wprot_q;

endmodule

// File: tb/tb_image_mem_responder.sv
// Directed table-driven bench for image_mem_responder (default parameters, RD_LAT=1).
module tb_image_mem_responder;

    logic clk;
    logic sclr;
    int   errors;
    int   checks;

    image_mem_responder_if bus ();

    image_mem_responder #(
        .MEM_DEPTH (32768),
        .OUT_BASE  (16'h4000),
        .RD_LAT    (1)
    ) dut (
        .clk  (clk),
        .sclr (sclr),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        busy;
        logic        clr;
        logic        hreq;
        logic        hwe;
        logic [15:0] haddr;
        logic [7:0]  hwd;
        logic        ce;
        logic        cwe;
        logic [15:0] caddr;
        logic [7:0]  cwd;
        logic        e_gnt;
        logic        e_rv;
        logic [7:0]  e_hrd;
        logic [7:0]  e_crd;
        logic [31:0] e_rdc;
        logic [31:0] e_wrc;
        logic        e_er;
        logic        e_wp;
    } vec_t;

    vec_t tbl [34];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s [%0d]: actual=%h required=%h", name, idx, act, exp);
        end
    endtask

    task automatic check_outputs(input int idx, input logic e_rv, input logic [7:0] e_hrd, input logic [7:0] e_crd,
                                 input logic [31:0] e_rdc, input logic [31:0] e_wrc, input logic e_er, input logic e_wp);
        check("host_rvalid", idx, 32'(bus.host_rvalid), 32'(e_rv));
        check("host_rdata",  idx, 32'(bus.host_rdata),  32'(e_hrd));
        check("core_rdata",  idx, 32'(bus.core_rdata),  32'(e_crd));
        check("rd_count",    idx, bus.rd_count,         e_rdc);
        check("wr_count",    idx, bus.wr_count,         e_wrc);
        check("err_range",   idx, 32'(bus.err_range),   32'(e_er));
        check("err_wprot",   idx, 32'(bus.err_wprot),   32'(e_wp));
    endtask

    task automatic drive_idle();
        bus.core_busy  = 1'b0;
        bus.core_ce    = 1'b0;
        bus.core_we    = 1'b0;
        bus.core_addr  = 16'h0000;
        bus.core_wdata = 8'h00;
        bus.host_req   = 1'b0;
        bus.host_we    = 1'b0;
        bus.host_addr  = 16'h0000;
        bus.host_wdata = 8'h00;
        bus.clr_stats  = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        // busy clr hreq hwe haddr hwd | ce cwe caddr cwd | gnt rv hrd crd rdc wrc er wp
        tbl[0]  = '{1'b0,1'b0,1'b1,1'b1,16'h0005,8'hAB, 1'b0,1'b0,16'h0000,8'h00, 1'b1,1'b0,8'h00,8'h00,32'd0,32'd0,1'b0,1'b0};
        tbl[1]  = '{1'b0,1'b0,1'b1,1'b1,16'h0006,8'hCD, 1'b0,1'b0,16'h0000,8'h00, 1'b1,1'b0,8'h00,8'h00,32'd0,32'd0,1'b0,1'b0};
        tbl[2]  = '{1'b0,1'b0,1'b1,1'b1,16'h0105,8'h12, 1'b0,1'b0,16'h0000,8'h00, 1'b1,1'b0,8'h00,8'h00,32'd0,32'd0,1'b0,1'b0};
        tbl[3]  = '{1'b0,1'b0,1'b1,1'b1,16'h0106,8'h34, 1'b0,1'b0,16'h0000,8'h00, 1'b1,1'b0,8'h00,8'h00,32'd0,32'd0,1'b0,1'b0};
        tbl[4]  = '{1'b0,1'b0,1'b1,1'b1,16'h0010,8'h99, 1'b0,1'b0,16'h0000,8'h00, 1'b1,1'b0,8'h00,8'h00,32'd0,32'd0,1'b0,1'b0};
        tbl[5]  = '{1'b0,1'b0,1'b1,1'b1,16'h0007,8'hEE, 1'b0,1'b0,16'h0000,8'h00, 1'b1,1'b0,8'h00,8'h00,32'd0,32'd0,1'b0,1'b0};
        tbl[6]  = '{1'b0,1'b0,1'b1,1'b0,16'h0007,8'h00, 1'b0,1'b0,16'h0000,8'h00, 1'b1,1'b1,8'hEE,8'h00,32'd0,32'd0,1'b0,1'b0};
        tbl[7]  = '{1'b0,1'b0,1'b1,1'b0,16'h0005,8'h00, 1'b0,1'b0,16'h0000,8'h00, 1'b1,1'b1,8'hAB,8'h00,32'd0,32'd0,1'b0,1'b0};
        tbl[8]  = '{1'b0,1'b0,1'b0,1'b0,16'h0005,8'h00, 1'b0,1'b0,16'h0000,8'h00, 1'b0,1'b0,8'hAB,8'h00,32'd0,32'd0,1'b0,1'b0};
        tbl[9]  = '{1'b1,1'b0,1'b1,1'b0,16'h0006,8'h00, 1'b0,1'b0,16'h0000,8'h00, 1'b0,1'b0,8'hAB,8'h00,32'd0,32'd0,1'b0,1'b0};
        tbl[10] = '{1'b1,1'b0,1'b1,1'b0,16'h0006,8'h00, 1'b1,1'b0,16'h0106,8'h00, 1'b0,1'b0,8'hAB,8'h00,32'd0,32'd0,1'b0,1'b0};
        tbl[11] = '{1'b1,1'b0,1'b1,1'b0,16'h0006,8'h00, 1'b1,1'b0,16'h0005,8'h00, 1'b0,1'b0,8'hAB,8'hAB,32'd1,32'd0,1'b0,1'b0};
        tbl[12] = '{1'b1,1'b0,1'b1,1'b0,16'h0006,8'h00, 1'b1,1'b0,16'h0006,8'h00, 1'b0,1'b0,8'hAB,8'hCD,32'd2,32'd0,1'b0,1'b0};
        tbl[13] = '{1'b1,1'b0,1'b1,1'b0,16'h0006,8'h00, 1'b1,1'b0,16'h0105,8'h00, 1'b0,1'b0,8'hAB,8'h12,32'd3,32'd0,1'b0,1'b0};
        tbl[14] = '{1'b1,1'b0,1'b1,1'b0,16'h0006,8'h00, 1'b1,1'b0,16'h0106,8'h00, 1'b0,1'b0,8'hAB,8'h34,32'd4,32'd0,1'b0,1'b0};
        tbl[15] = '{1'b1,1'b0,1'b1,1'b0,16'h0006,8'h00, 1'b1,1'b0,16'h0005,8'h00, 1'b0,1'b0,8'hAB,8'hAB,32'd5,32'd0,1'b0,1'b0};
        for (int k = 16; k <= 20; k++) begin
            tbl[k] = '{1'b1,1'b0,1'b1,1'b0,16'h0006,8'h00, 1'b0,1'b0,16'h0006,8'h00, 1'b0,1'b0,8'hAB,8'hAB,32'd5,32'd0,1'b0,1'b0};
        end
        tbl[21] = '{1'b1,1'b0,1'b1,1'b0,16'h0006,8'h00, 1'b1,1'b0,16'h0006,8'h00, 1'b0,1'b0,8'hAB,8'hCD,32'd6,32'd0,1'b0,1'b0};
        tbl[22] = '{1'b1,1'b0,1'b1,1'b0,16'h0006,8'h00, 1'b1,1'b1,16'h0010,8'h55, 1'b0,1'b0,8'hAB,8'hCD,32'd6,32'd0,1'b0,1'b1};
        tbl[23] = '{1'b1,1'b0,1'b1,1'b0,16'h0006,8'h00, 1'b1,1'b0,16'h9000,8'h00, 1'b0,1'b0,8'hAB,8'h00,32'd7,32'd0,1'b1,1'b1};
        tbl[24] = '{1'b1,1'b0,1'b1,1'b0,16'h0006,8'h00, 1'b1,1'b1,16'h4000,8'h77, 1'b0,1'b0,8'hAB,8'h00,32'd7,32'd1,1'b1,1'b1};
        tbl[25] = '{1'b1,1'b0,1'b1,1'b0,16'h0006,8'h00, 1'b1,1'b0,16'h4000,8'h00, 1'b0,1'b0,8'hAB,8'h77,32'd8,32'd1,1'b1,1'b1};
        tbl[26] = '{1'b1,1'b0,1'b1,1'b0,16'h0006,8'h00, 1'b1,1'b0,16'h0010,8'h00, 1'b0,1'b0,8'hAB,8'h99,32'd9,32'd1,1'b1,1'b1};
        tbl[27] = '{1'b0,1'b0,1'b1,1'b0,16'h4000,8'h00, 1'b0,1'b0,16'h0000,8'h00, 1'b0,1'b0,8'hAB,8'h99,32'd9,32'd1,1'b1,1'b1};
        tbl[28] = '{1'b0,1'b0,1'b1,1'b0,16'h4000,8'h00, 1'b0,1'b0,16'h0000,8'h00, 1'b1,1'b1,8'h77,8'h99,32'd9,32'd1,1'b1,1'b1};
        tbl[29] = '{1'b0,1'b0,1'b1,1'b0,16'h0010,8'h00, 1'b0,1'b0,16'h0000,8'h00, 1'b1,1'b1,8'h99,8'h99,32'd9,32'd1,1'b1,1'b1};
        tbl[30] = '{1'b0,1'b0,1'b1,1'b1,16'h9000,8'h5A, 1'b0,1'b0,16'h0000,8'h00, 1'b1,1'b0,8'h99,8'h99,32'd9,32'd1,1'b1,1'b1};
        tbl[31] = '{1'b0,1'b1,1'b1,1'b0,16'h0005,8'h00, 1'b0,1'b0,16'h0000,8'h00, 1'b1,1'b1,8'hAB,8'h99,32'd0,32'd0,1'b0,1'b0};
        tbl[32] = '{1'b0,1'b0,1'b1,1'b0,16'h9001,8'h00, 1'b0,1'b0,16'h0000,8'h00, 1'b1,1'b1,8'h00,8'h99,32'd0,32'd0,1'b1,1'b0};
        tbl[33] = '{1'b0,1'b1,1'b1,1'b0,16'h9002,8'h00, 1'b0,1'b0,16'h0000,8'h00, 1'b1,1'b1,8'h00,8'h99,32'd0,32'd0,1'b0,1'b0};

        // Power-on reset
        drive_idle();
        sclr = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        sclr = 1'b0;
        #1;
        check("reset host_gnt", -1, 32'(bus.host_gnt), 32'd0);
        check_outputs(-1, 1'b0, 8'h00, 8'h00, 32'd0, 32'd0, 1'b0, 1'b0);

        for (int i = 0; i < 34; i++) begin
            bus.core_busy  = tbl[i].busy;
            bus.clr_stats  = tbl[i].clr;
            bus.host_req   = tbl[i].hreq;
            bus.host_we    = tbl[i].hwe;
            bus.host_addr  = tbl[i].haddr;
            bus.host_wdata = tbl[i].hwd;
            bus.core_ce    = tbl[i].ce;
            bus.core_we    = tbl[i].cwe;
            bus.core_addr  = tbl[i].caddr;
            bus.core_wdata = tbl[i].cwd;
            #1;
            check("host_gnt", i, 32'(bus.host_gnt), 32'(tbl[i].e_gnt));
            @(posedge clk);
            #1;
            check_outputs(i, tbl[i].e_rv, tbl[i].e_hrd, tbl[i].e_crd, tbl[i].e_rdc,
                          tbl[i].e_wrc, tbl[i].e_er, tbl[i].e_wp);
        end

        // Build up non-zero state, then reset with random inputs applied during sclr.
        drive_idle();
        bus.core_busy = 1'b0;
        bus.host_req  = 1'b1;
        bus.host_addr = 16'h0005;
        @(posedge clk);
        #1;
        check("pre-reset host_rdata", 100, 32'(bus.host_rdata), 32'h0000_00AB);
        bus.core_busy  = 1'($urandom);
        bus.core_ce    = 1'($urandom);
        bus.core_we    = 1'($urandom);
        bus.core_addr  = 16'($urandom);
        bus.core_wdata = 8'($urandom);
        bus.host_req   = 1'($urandom);
        bus.host_we    = 1'($urandom);
        bus.host_addr  = 16'($urandom);
        bus.host_wdata = 8'($urandom);
        bus.clr_stats  = 1'($urandom);
        sclr = 1'b1;
        @(posedge clk);
        #1;
        sclr = 1'b0;
        drive_idle();
        #1;
        check("sclr host_gnt", 101, 32'(bus.host_gnt), 32'd0);
        check_outputs(101, 1'b0, 8'h00, 8'h00, 32'd0, 32'd0, 1'b0, 1'b0);

        // Owner must be HOST_OWN immediately: host read of RAM contents kept across reset.
        bus.host_req  = 1'b1;
        bus.host_addr = 16'h0005;
        #1;
        check("post-reset host_gnt", 102, 32'(bus.host_gnt), 32'd1);
        @(posedge clk);
        #1;
        check("post-reset host_rvalid", 102, 32'(bus.host_rvalid), 32'd1);
        check("post-reset host_rdata", 102, 32'(bus.host_rdata), 32'h0000_00AB);
        bus.host_req = 1'b0;
        @(posedge clk);
        #1;
        check("rvalid single pulse", 103, 32'(bus.host_rvalid), 32'd0);
        check("host_rdata held", 103, 32'(bus.host_rdata), 32'h0000_00AB);

        // Handover round-trip: busy raised then dropped; grant must come back within a bounded window.
        bus.core_busy = 1'b1;
        bus.host_req  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.core_busy = 1'b0;
        begin
            int wait_cycles;
            wait_cycles = 0;
            #1;
            while (bus.host_gnt !== 1'b1 && wait_cycles < 4) begin
                @(posedge clk);
                #2;
                wait_cycles = wait_cycles + 1;
            end
            check("regrant latency", 104, 32'(wait_cycles), 32'd1);
        end

        drive_idle();
        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
